// File: rtl/csi_rx_raw8_pixel_stream.sv
// RAW8 pixel streamer: buffers 32-bit CSI payload words with line/frame tags and
// serialises them into a registered one-pixel-per-cycle valid/ready stream with coordinates.
module csi_rx_raw8_pixel_stream #(
    parameter int FIFO_DEPTH = 8,
    parameter int XW         = 12,
    parameter int YW         = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [31:0]   payload_data,
    input  logic          payload_enable,
    input  logic          in_line,
    input  logic          in_frame,
    input  logic          out_ready,
    output logic [7:0]    pix_data,
    output logic          pix_valid,
    output logic          pix_sol,
    output logic          pix_sof,
    output logic [XW-1:0] pix_x,
    output logic [YW-1:0] pix_y,
    output logic [XW+1:0] line_len,
    output logic          line_done,
    output logic          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic        sof;
        logic        sol;
        logic [31:0] data;
    } entry_t;

    entry_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          in_line_q, in_frame_q;
    logic          armed_q, armed_d, sol_pend_q, sol_pend_d, sof_pend_q, sof_pend_d;
    logic          overflow_q, overflow_d, line_done_q, line_done_d;
    logic [XW+1:0] line_cnt_q, line_cnt_d, line_len_q, line_len_d;
    logic          pix_valid_q, pix_valid_d, pix_sol_q, pix_sol_d, pix_sof_q, pix_sof_d;
    logic [7:0]    pix_data_q, pix_data_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;
    logic [1:0]    byte_idx_q, byte_idx_d, byte_nxt;

    logic          line_rise, line_fall, frame_rise, armed, full;
    logic          wr_req, push, pop, sol_tag, sof_tag, src_ok;
    logic [AW-1:0] next_ptr;
    entry_t        head, src;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        line_rise  = in_line && !in_line_q;
        line_fall  = !in_line && in_line_q && armed_q;
        frame_rise = in_frame && !in_frame_q;
        armed      = armed_q || line_rise;
        full       = (cnt_q == FULL_CNT);
        pop        = pix_valid_q && out_ready && (byte_idx_q == 2'd3);
        wr_req     = payload_enable && in_line && armed;
        push       = wr_req && (!full || pop);
        sol_tag    = sol_pend_q || line_rise;
        sof_tag    = sol_tag && (sof_pend_q || frame_rise);

        armed_d    = armed;
        sol_pend_d = sol_tag && !push;
        sof_pend_d = (sof_pend_q || frame_rise) && !(push && sol_tag);
        overflow_d = overflow_q || (wr_req && full && !pop);
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d      = cnt_q;
        if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
        else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);

        line_cnt_d  = push ? line_cnt_q + (XW+2)'(4) : line_cnt_q;
        line_len_d  = line_len_q;
        line_done_d = 1'b0;
        if (line_fall) begin
            line_len_d  = line_cnt_q;
            line_done_d = 1'b1;
            line_cnt_d  = '0;
        end

        // The head word stays in the FIFO until its last byte is handed off, so the
        // word that follows it is read one slot ahead.
        next_ptr = rd_ptr_q + AW'(1);
        head     = mem_q[rd_ptr_q];
        src      = pix_valid_q ? mem_q[next_ptr] : head;
        src_ok   = pix_valid_q ? (cnt_q > (AW+1)'(1)) : (cnt_q != '0);
        byte_nxt = byte_idx_q + 2'd1;

        pix_valid_d = pix_valid_q;
        pix_data_d  = pix_data_q;
        pix_sol_d   = pix_sol_q;
        pix_sof_d   = pix_sof_q;
        pix_x_d     = pix_x_q;
        pix_y_d     = pix_y_q;
        byte_idx_d  = byte_idx_q;
        if (!pix_valid_q || out_ready) begin
            if (pix_valid_q && byte_idx_q != 2'd3) begin
                byte_idx_d = byte_nxt;
                pix_data_d = head.data[{byte_nxt, 3'b000} +: 8];
                pix_sol_d  = 1'b0;
                pix_sof_d  = 1'b0;
                pix_x_d    = pix_x_q + XW'(1);
            end else if (src_ok) begin
                pix_valid_d = 1'b1;
                byte_idx_d  = 2'd0;
                pix_data_d  = src.data[7:0];
                pix_sol_d   = src.sol;
                pix_sof_d   = src.sof;
                pix_x_d     = src.sol ? '0 : pix_x_q + XW'(1);
                if (src.sof)      pix_y_d = '0;
                else if (src.sol) pix_y_d = pix_y_q + YW'(1);
            end else begin
                pix_valid_d = 1'b0;
                pix_sol_d   = 1'b0;
                pix_sof_d   = 1'b0;
            end
        end
    end

    // NOTE: payload storage carries no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= entry_t'{sof: sof_tag, sol: sol_tag, data: payload_data};
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so all of them update together.
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            // Held high so a line or frame already in progress is not seen as a new rise.
            in_line_q   <= 1'b1;
            in_frame_q  <= 1'b1;
            armed_q     <= 1'b0;
            sol_pend_q  <= 1'b0;
            sof_pend_q  <= 1'b0;
            overflow_q  <= 1'b0;
            line_cnt_q  <= '0;
            line_len_q  <= '0;
            line_done_q <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            pix_sol_q   <= 1'b0;
            pix_sof_q   <= 1'b0;
            pix_x_q     <= '0;
            pix_y_q     <= '0;
            byte_idx_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            in_line_q   <= in_line;
            in_frame_q  <= in_frame;
            armed_q     <= armed_d;
            sol_pend_q  <= sol_pend_d;
            sof_pend_q  <= sof_pend_d;
            overflow_q  <= overflow_d;
            line_cnt_q  <= line_cnt_d;
            line_len_q  <= line_len_d;
            line_done_q <= line_done_d;
            pix_valid_q <= pix_valid_d;
            pix_data_q  <= pix_data_d;
            pix_sol_q   <= pix_sol_d;
            pix_sof_q   <= pix_sof_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            byte_idx_q  <= byte_idx_d;
        end
    end

    assign pix_data  = pix_data_q;
    assign pix_valid = pix_valid_q;
    assign pix_sol   = pix_sol_q;
    assign pix_sof   = pix_sof_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign line_len  = line_len_q;
    assign line_done = line_done_q;
    assign overflow  = overflow_q;
endmodule
